// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one bit-serial AND/OR/NOT unit among N_REQ requesters.
// The 1-bit cells are kept in this file so the block is self-contained.
module and_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

module or_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i | b_i;
endmodule

module not_gate (
    input  logic a_i,
    output logic y_o
);
    assign y_o = ~a_i;
endmodule

// state | meaning
// IDLE  | no operation in flight, arbitrate on any req
// RUN   | evaluating bit cnt_q of the latched operands
// DONE  | result valid (done pulse), arbitrate again or fall back to IDLE
module logic_op_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [2*N_REQ-1:0]       op,
    input  logic [N_REQ*WIDTH-1:0]   a_in,
    input  logic [N_REQ*WIDTH-1:0]   b_in,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic [WIDTH-1:0]         result
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [N_REQ-1:0]   win_oh;
    logic [1:0]         op_sel;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic               and_y, or_y, not_y, bit_res;

    // Search downward so the closest index after last_q is the final one written.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = int'(last_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        win_oh = '0;
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_oh[i] = win_found && (win_id == ID_W'(i));
            if (win_oh[i]) begin
                op_sel = op[2*i +: 2];
                a_sel  = a_in[i*WIDTH +: WIDTH];
                b_sel  = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    and_gate u_and (.a_i(a_q[cnt_q]), .b_i(b_q[cnt_q]), .y_o(and_y));
    or_gate  u_or  (.a_i(a_q[cnt_q]), .b_i(b_q[cnt_q]), .y_o(or_y));
    not_gate u_not (.a_i(a_q[cnt_q]), .y_o(not_y));

    always_comb begin
        case (op_q)
            2'b00:   bit_res = and_y;
            2'b01:   bit_res = or_y;
            2'b10:   bit_res = not_y;
            default: bit_res = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        id_d      = id_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        shadow_d  = shadow_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (win_found) begin
                    gnt_d   = win_oh;
                    last_d  = win_id;
                    id_d    = win_id;
                    op_d    = op_sel;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                shadow_d[cnt_q] = bit_res;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    result_d  = shadow_d;
                    done_id_d = id_q;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= ID_W'(N_REQ-1);
            id_q      <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            shadow_q  <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            id_q      <= id_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            shadow_q  <= shadow_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign result  = result_q;
endmodule

// File: tb/tb_logic_op_scheduler.sv
// Scoreboard bench for logic_op_scheduler: directed ops queue expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_logic_op_scheduler;
    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op;
    logic [N_REQ*WIDTH-1:0] a_in, b_in;
    logic [N_REQ-1:0]       gnt;
    logic                   busy, done;
    logic [ID_W-1:0]        done_id;
    logic [WIDTH-1:0]       result;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [WIDTH-1:0] exp_res[$];
    logic [ID_W-1:0]  exp_id[$];

    logic_op_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_res.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got id %0d result %0h, expected no done", done_id, result);
            end else begin
                logic [WIDTH-1:0] er;
                logic [ID_W-1:0]  ei;
                er = exp_res.pop_front();
                ei = exp_id.pop_front();
                check("done_result", 32'(result), 32'(er));
                check("done_id", 32'(done_id), 32'(ei));
            end
        end
    end

    task automatic set_op(input int i, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        op[2*i +: 2]         = o;
        a_in[i*WIDTH +: WIDTH] = a;
        b_in[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic expect_done(input int i, input logic [7:0] r);
        exp_res.push_back(r);
        exp_id.push_back(ID_W'(i));
    endtask

    task automatic wait_gnt(output logic [N_REQ-1:0] g, output int t);
        bit seen = 0;
        g = '0;
        t = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g = gnt;
                t = cyc;
                seen = 1;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL gnt_timeout: got no grant, expected one within 40 cycles");
        end
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (exp_res.size() == 0 && !busy && !done) ok = 1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_res.size());
        end
    endtask

    task automatic do_op(input int i, input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] r);
        logic [N_REQ-1:0] g;
        int t;
        set_op(i, o, a, b);
        expect_done(i, r);
        req[i] = 1'b1;
        wait_gnt(g, t);
        check("gnt_onehot", 32'(g), 32'(1) << i);
        req[i] = 1'b0;
        drain();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N_REQ-1:0] g;
        int t, prev;
        rst = 1'b1; req = '0; op = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_done_id", 32'(done_id), 0);
        check("rst_result", 32'(result), 0);
        rst = 1'b0;

        // first op: latency and busy window
        set_op(0, 2'b00, 8'hF0, 8'h3C);
        expect_done(0, 8'h30);
        req = 4'b0001;
        wait_gnt(g, t);
        check("t1_gnt", 32'(g), 32'b0001);
        check("t1_busy_at_gnt", 32'(busy), 1);
        req = '0;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            check("t1_busy_run", 32'({busy, done, gnt}), 32'b1_0_0000);
        end
        @(negedge clk);
        check("t1_done_edge", 32'({busy, done, gnt}), 32'b0_1_0000);
        drain();
        check("t1_hold_result", 32'(result), 32'h30);

        do_op(2, 2'b01, 8'hA5, 8'h0F, 8'hAF);
        do_op(2, 2'b10, 8'hA5, 8'h00, 8'h5A);

        // all four held: round-robin order and WIDTH+1 spacing
        do_reset();
        set_op(0, 2'b00, 8'hCC, 8'hAA);
        set_op(1, 2'b01, 8'h12, 8'h40);
        set_op(2, 2'b10, 8'h3C, 8'h55);
        set_op(3, 2'b00, 8'hFF, 8'h81);
        expect_done(0, 8'h88);
        expect_done(1, 8'h52);
        expect_done(2, 8'hC3);
        expect_done(3, 8'h81);
        expect_done(0, 8'h88);
        req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, t);
            check("rr_gnt", 32'(g), 32'(1) << (k % 4));
            if (k > 0) check("rr_spacing", 32'(t - prev), 9);
            prev = t;
        end
        req = '0;
        drain();

        do_op(3, 2'b11, 8'hFF, 8'hFF, 8'h00);

        // operands change after grant must be ignored
        set_op(0, 2'b00, 8'h0F, 8'hFF);
        expect_done(0, 8'h0F);
        req = 4'b0001;
        wait_gnt(g, t);
        check("latch_gnt", 32'(g), 32'b0001);
        req = '0;
        a_in[0 +: WIDTH] = 8'hFF;
        drain();

        // reset during RUN cycle 4
        set_op(0, 2'b00, 8'h55, 8'hFF);
        req = 4'b0001;
        wait_gnt(g, t);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outputs", 32'({busy, done, gnt}), 0);
        check("mid_rst_result", 32'(result), 0);
        rst = 1'b0;
        set_op(0, 2'b01, 8'h11, 8'h22);
        set_op(1, 2'b10, 8'h0F, 8'h00);
        expect_done(0, 8'h33);
        expect_done(1, 8'hF0);
        req = 4'b0011;
        wait_gnt(g, t);
        check("post_rst_gnt", 32'(g), 32'b0001);
        req = 4'b0010;
        wait_gnt(g, t);
        check("post_rst_gnt2", 32'(g), 32'b0010);
        req = '0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
